// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: sync pattern, zero-stuffed MSB-first payload, one idle guard bit.
// Outputs are registered one cycle behind the state that produces them.
//
// state | meaning
// IDLE  | line at 0, READY high, waiting for LOAD
// PRE   | shifting out the sync pattern MSB-first
// DATA  | shifting out payload bits MSB-first
// STUFF | inserted 0 after two consecutive payload 1s
// GAP   | guard bit at 0, DONE pulse, back to IDLE
module serial_pattern_tx #(
    parameter int                 PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PAT     = 5'b10111,
    parameter int                 DATA_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DIN,
    input  logic              LOAD,
    output logic              READY,
    output logic              OUT,
    output logic              BUSY,
    output logic              DONE
);

    localparam int PC_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam int BC_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        STUFF,
        GAP
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shift_reg;
    logic [PC_W-1:0]   pat_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic [1:0]        ones_cnt;
    logic              cur_bit;

    assign cur_bit = shift_reg[DATA_W-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            shift_reg <= '0;
            pat_cnt   <= '0;
            bit_cnt   <= '0;
            ones_cnt  <= '0;
            OUT       <= 1'b0;
            READY     <= 1'b1;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    OUT   <= 1'b0;
                    READY <= 1'b1;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    if (LOAD) begin
                        shift_reg <= DIN;
                        pat_cnt   <= PC_W'(PAT_LEN - 1);
                        bit_cnt   <= BC_W'(DATA_W);
                        ones_cnt  <= '0;
                        state     <= PRE;
                    end
                end
                PRE: begin
                    // pat_cnt counts down, so PAT[pat_cnt] walks the pattern MSB-first
                    OUT   <= PAT[pat_cnt];
                    READY <= 1'b0;
                    BUSY  <= 1'b1;
                    DONE  <= 1'b0;
                    if (pat_cnt == '0) begin
                        state <= DATA;
                    end else begin
                        pat_cnt <= pat_cnt - PC_W'(1);
                    end
                end
                DATA: begin
                    OUT       <= cur_bit;
                    READY     <= 1'b0;
                    BUSY      <= 1'b1;
                    DONE      <= 1'b0;
                    shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                    bit_cnt   <= bit_cnt - BC_W'(1);
                    if (cur_bit) begin
                        ones_cnt <= ones_cnt + 2'd1;
                        // second 1 in a row: stuff even after the last payload bit
                        if (ones_cnt == 2'd1) begin
                            state <= STUFF;
                        end else if (bit_cnt == BC_W'(1)) begin
                            state <= GAP;
                        end
                    end else begin
                        ones_cnt <= '0;
                        if (bit_cnt == BC_W'(1)) begin
                            state <= GAP;
                        end
                    end
                end
                STUFF: begin
                    OUT      <= 1'b0;
                    READY    <= 1'b0;
                    BUSY     <= 1'b1;
                    DONE     <= 1'b0;
                    ones_cnt <= '0;
                    state    <= (bit_cnt == '0) ? GAP : DATA;
                end
                GAP: begin
                    OUT   <= 1'b0;
                    READY <= 1'b0;
                    BUSY  <= 1'b1;
                    DONE  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: frame contents, stuffing, load gating,
// mid-frame reset and back-to-back frames, each checked by immediate assertion.
module tb_serial_pattern_tx;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] DIN;
    logic       LOAD;
    logic       READY;
    logic       OUT;
    logic       BUSY;
    logic       DONE;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] E00 = 32'(14'b10111_00000000_0);
    localparam logic [31:0] EFF = 32'(18'b10111_110110110110_0);
    localparam logic [31:0] EB7 = 32'(16'b10111_1011001101_0);

    serial_pattern_tx dut (
        .CLK  (CLK),
        .RST  (RST),
        .DIN  (DIN),
        .LOAD (LOAD),
        .READY(READY),
        .OUT  (OUT),
        .BUSY (BUSY),
        .DONE (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse LOAD for one edge from IDLE; OUT must still be idle one cycle later.
    task automatic start(input logic [7:0] d);
        DIN  = d;
        LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
        chk("latency_out", 32'(OUT), 32'd0);
        chk("latency_ready", 32'(READY), 32'd1);
    endtask

    // Collect OUT until DONE (bounded); optionally pulse LOAD/DIN=55 mid-frame.
    task automatic capture(input int inj_at, output int len, output logic [31:0] bits,
                           output int bad);
        len  = 0;
        bits = '0;
        bad  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            bits = {bits[30:0], OUT};
            len++;
            if (BUSY !== 1'b1 || READY !== 1'b0) bad++;
            if (i == inj_at) begin
                DIN  = 8'h55;
                LOAD = 1'b1;
            end else begin
                LOAD = 1'b0;
            end
            if (DONE === 1'b1) break;
        end
        LOAD = 1'b0;
    endtask

    task automatic after_frame(input string tag);
        @(negedge CLK);
        chk({tag, "_ready_after"}, 32'(READY), 32'd1);
        chk({tag, "_done_after"}, 32'(DONE), 32'd0);
        chk({tag, "_busy_after"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        int          len;
        logic [31:0] bits;
        int          bad;
        int          cnt;
        int          mpos;
        int          dpos [3];
        logic [4:0]  win;

        RST  = 1'b1;
        LOAD = 1'b0;
        DIN  = 8'h00;
        repeat (2) @(negedge CLK);
        chk("rst_out", 32'(OUT), 32'd0);
        chk("rst_ready", 32'(READY), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // 8'h00: no stuffing, 14-cycle frame
        start(8'h00);
        capture(-1, len, bits, bad);
        chk("f00_len", 32'(len), 32'd14);
        chk("f00_bits", bits, E00);
        chk("f00_busy_ready", 32'(bad), 32'd0);
        after_frame("f00");

        // 8'hFF: maximal stuffing including after the last bit
        start(8'hFF);
        capture(-1, len, bits, bad);
        chk("fFF_len", 32'(len), 32'd18);
        chk("fFF_bits", bits, EFF);
        after_frame("fFF");

        // 8'hB7: mixed stuffing; sync pattern must match only once, at its end
        start(8'hB7);
        capture(-1, len, bits, bad);
        chk("fB7_len", 32'(len), 32'd16);
        chk("fB7_bits", bits, EB7);
        cnt  = 0;
        mpos = -1;
        win  = '0;
        for (int i = 0; i < len && i < 32; i++) begin
            win = {win[3:0], bits[len-1-i]};
            if (i >= 4 && win == 5'b10111) begin
                cnt++;
                if (mpos < 0) mpos = i;
            end
        end
        chk("fB7_match_count", 32'(cnt), 32'd1);
        chk("fB7_match_pos", 32'(mpos), 32'd4);
        after_frame("fB7");

        // LOAD with 8'h55 during a frame is ignored
        start(8'hFF);
        capture(3, len, bits, bad);
        chk("ign_len", 32'(len), 32'd18);
        chk("ign_bits", bits, EFF);
        cnt = 0;
        repeat (20) begin
            @(negedge CLK);
            if (BUSY !== 1'b0 || OUT !== 1'b0) cnt++;
        end
        chk("ign_no_second_frame", 32'(cnt), 32'd0);

        // Reset during the third payload bit of an 8'hFF frame
        start(8'hFF);
        bits = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            bits = {bits[30:0], OUT};
        end
        chk("rstmid_prefix", bits, 32'(8'b10111_110));
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rstmid_out", 32'(OUT), 32'd0);
        chk("rstmid_ready", 32'(READY), 32'd1);
        chk("rstmid_busy", 32'(BUSY), 32'd0);
        chk("rstmid_done", 32'(DONE), 32'd0);
        cnt = 0;
        repeat (20) begin
            @(negedge CLK);
            if (DONE !== 1'b0 || BUSY !== 1'b0) cnt++;
        end
        chk("rstmid_no_done", 32'(cnt), 32'd0);
        start(8'h00);
        capture(-1, len, bits, bad);
        chk("rstmid_clean_len", 32'(len), 32'd14);
        chk("rstmid_clean_bits", bits, E00);
        after_frame("rstmid");

        // RST and LOAD together: reset wins
        RST  = 1'b1;
        LOAD = 1'b1;
        DIN  = 8'hFF;
        @(negedge CLK);
        RST  = 1'b0;
        LOAD = 1'b0;
        cnt  = 0;
        repeat (4) begin
            @(negedge CLK);
            if (BUSY !== 1'b0 || OUT !== 1'b0 || READY !== 1'b1) cnt++;
        end
        chk("rst_load_no_frame", 32'(cnt), 32'd0);

        // LOAD held high: three 8'h00 frames, DONE every 15 cycles
        DIN  = 8'h00;
        LOAD = 1'b1;
        cnt  = 0;
        bad  = 0;
        dpos = '{default: -1};
        for (int t = 1; t <= 60; t++) begin
            @(negedge CLK);
            if (t == 35) LOAD = 1'b0;
            if (OUT === 1'b1) bad++;
            if (DONE === 1'b1) begin
                if (cnt < 3) dpos[cnt] = t;
                cnt++;
            end
            if (t == 16) chk("b2b_idle_gap_out", 32'(OUT), 32'd0);
            if (t == 16) chk("b2b_idle_gap_ready", 32'(READY), 32'd1);
            if (t == 17) chk("b2b_second_start", 32'(OUT), 32'd1);
        end
        chk("b2b_done_count", 32'(cnt), 32'd3);
        chk("b2b_done0", 32'(dpos[0]), 32'd15);
        chk("b2b_done1", 32'(dpos[1]), 32'd30);
        chk("b2b_done2", 32'(dpos[2]), 32'd45);
        chk("b2b_ones", 32'(bad), 32'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
